// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture and playback paths.
package audio_pkg;

    localparam int ADDR_W  = 16;
    localparam int AUDIO_W = 24;
    localparam int PACK_W  = 16;

    localparam logic TLAST_LEFT  = 1'b0;
    localparam logic TLAST_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CAP_L,
        ST_CAP_R,
        ST_WRITE,
        ST_DONE
    } rec_state_e;

endpackage

// File: rtl/stereo_packer.sv
// Latches left/right samples into one packed frame word, keeping only the top
// PACK_W bits of each 24-bit sample, and flags out-of-order channels.
module stereo_packer
    import audio_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        expectLeft_i,
    input  logic        expectRight_i,
    input  logic        valid_i,
    input  logic        last_i,
    input  logic [31:0] data_i,
    output logic [31:0] din_o,
    output logic        leftLatched_o,
    output logic        rightLatched_o,
    output logic        syncErr_o
);

    logic [PACK_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              err_q, err_d;
    logic              isLeft;
    logic [PACK_W-1:0] sample;
    logic              unusedBits;

    assign isLeft     = (last_i == TLAST_LEFT);
    assign sample     = data_i[AUDIO_W-1 -: PACK_W];
    assign unusedBits = ^{data_i[31:AUDIO_W], data_i[AUDIO_W-PACK_W-1:0]};

    assign leftLatched_o  = expectLeft_i && valid_i && isLeft;
    assign rightLatched_o = expectRight_i && valid_i && !isLeft;

    // A stray left while waiting for right replaces the pending left half
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        err_d = err_q;
        if (clear_i) begin
            err_d = 1'b0;
        end
        if (expectLeft_i && valid_i) begin
            if (isLeft) begin
                hi_d = sample;
            end else begin
                err_d = 1'b1;
            end
        end
        if (expectRight_i && valid_i) begin
            if (!isLeft) begin
                lo_d = sample;
            end else begin
                hi_d  = sample;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            err_q <= err_d;
        end
    end

    assign din_o     = {hi_q, lo_q};
    assign syncErr_o = err_q;

endmodule

// File: rtl/audio_recorder.sv
// Records the I2S receiver stream into audio BRAM, one packed L/R frame per
// address, sweeping 0..RAM_DEPTH like the playback reader.
module audio_recorder #(
    parameter int RAM_DEPTH = 65278,
    parameter int ADDR_W    = audio_pkg::ADDR_W,
    parameter bit LOOP      = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              bram_en,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic              sync_err
);
    import audio_pkg::*;

    rec_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d, wrapped_q, wrapped_d, ready_q;
    logic              atLast, launch, expectLeft, expectRight;
    logic              leftLatched, rightLatched;

    assign atLast = (addr_q == ADDR_W'(RAM_DEPTH));
    assign launch = (state_q == ST_IDLE || state_q == ST_DONE) && start && !stop;
    // The WRITE cycle doubles as the next left capture so frames can be 2 cycles apart
    assign expectLeft  = !stop && ((state_q == ST_CAP_L) ||
                                   (state_q == ST_WRITE && (LOOP || !atLast)));
    assign expectRight = !stop && (state_q == ST_CAP_R);

    stereo_packer u_packer (
        .clock          (clock),
        .reset          (reset),
        .clear_i        (launch),
        .expectLeft_i   (expectLeft),
        .expectRight_i  (expectRight),
        .valid_i        (s_axis_tvalid),
        .last_i         (s_axis_tlast),
        .data_i         (s_axis_tdata),
        .din_o          (bram_din),
        .leftLatched_o  (leftLatched),
        .rightLatched_o (rightLatched),
        .syncErr_o      (sync_err)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        done_d    = done_q;
        wrapped_d = wrapped_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d   = ST_SYNC;
                    addr_d    = '0;
                    done_d    = 1'b0;
                    wrapped_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (s_axis_tvalid && s_axis_tlast == TLAST_RIGHT) begin
                    state_d = ST_CAP_L;
                end
            end
            ST_CAP_L: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (leftLatched) begin
                    state_d = ST_CAP_R;
                end
            end
            ST_CAP_R: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (rightLatched) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // On stop the address is left pointing at the frame just written
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (atLast && !LOOP) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = atLast ? '0 : addr_q + 1'b1;
                    state_d = leftLatched ? ST_CAP_R : ST_CAP_L;
                    if (atLast) begin
                        wrapped_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
            ready_q   <= 1'b1;
        end
    end

    assign busy          = (state_q == ST_SYNC) || (state_q == ST_CAP_L) ||
                           (state_q == ST_CAP_R) || (state_q == ST_WRITE);
    assign bram_en       = busy;
    assign bram_we       = (state_q == ST_WRITE);
    assign bram_addr     = addr_q;
    assign done          = done_q;
    assign wrapped       = wrapped_q;
    assign s_axis_tready = ready_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Scoreboard bench for audio_recorder: two small-depth instances (stop-when-full
// and looping) share one stimulus stream; expected BRAM writes are queued per instance.
module tb_audio_recorder;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] din;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop;
    logic [31:0] tdata;
    logic        tvalid, tlast;

    logic        stopReady, stopEn, stopWe, stopBusy, stopDone, stopWrapped, stopErr;
    logic [15:0] stopAddr;
    logic [31:0] stopDin;
    logic        loopReady, loopEn, loopWe, loopBusy, loopDone, loopWrapped, loopErr;
    logic [15:0] loopAddr;
    logic [31:0] loopDin;

    wr_t expStop[$];
    wr_t expLoop[$];
    wr_t eStop, eLoop;
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clock = ~clock;

    audio_recorder #(.RAM_DEPTH(3), .ADDR_W(16), .LOOP(1'b0)) dutStop (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(stopReady), .bram_addr(stopAddr), .bram_din(stopDin),
        .bram_en(stopEn), .bram_we(stopWe), .busy(stopBusy), .done(stopDone),
        .wrapped(stopWrapped), .sync_err(stopErr)
    );

    audio_recorder #(.RAM_DEPTH(3), .ADDR_W(16), .LOOP(1'b1)) dutLoop (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(loopReady), .bram_addr(loopAddr), .bram_din(loopDin),
        .bram_en(loopEn), .bram_we(loopWe), .busy(loopBusy), .done(loopDone),
        .wrapped(loopWrapped), .sync_err(loopErr)
    );

    // Every write strobe must match the oldest expected write for that instance
    always @(negedge clock) begin
        if (stopWe === 1'b1) begin
            vectors++;
            if (expStop.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL stop_write unexpected addr=%0d din=%h, required no write", stopAddr, stopDin);
            end else begin
                eStop = expStop.pop_front();
                if (stopAddr !== eStop.addr || stopDin !== eStop.din || stopEn !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL stop_write got addr=%0d din=%h en=%b, required addr=%0d din=%h en=1",
                             stopAddr, stopDin, stopEn, eStop.addr, eStop.din);
                end
            end
        end
        if (loopWe === 1'b1) begin
            vectors++;
            if (expLoop.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL loop_write unexpected addr=%0d din=%h, required no write", loopAddr, loopDin);
            end else begin
                eLoop = expLoop.pop_front();
                if (loopAddr !== eLoop.addr || loopDin !== eLoop.din || loopEn !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL loop_write got addr=%0d din=%h en=%b, required addr=%0d din=%h en=1",
                             loopAddr, loopDin, loopEn, eLoop.addr, eLoop.din);
                end
            end
        end
    end

    function automatic logic [31:0] packFrame(input logic [23:0] l, input logic [23:0] r);
        return {l[23:8], r[23:8]};
    endfunction

    task automatic applyStimulus(input logic v, input logic lst, input logic [23:0] smp,
                                 input logic st, input logic sp);
        tvalid = v;
        tlast  = lst;
        tdata  = {8'hA5, smp};
        start  = st;
        stop   = sp;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic sendL(input logic [23:0] s);
        applyStimulus(1'b1, 1'b0, s, 1'b0, 1'b0);
    endtask

    task automatic sendR(input logic [23:0] s);
        applyStimulus(1'b1, 1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic pushBoth(input logic [15:0] a, input logic [31:0] d);
        expStop.push_back('{addr: a, din: d});
        expLoop.push_back('{addr: a, din: d});
    endtask

    task automatic checkDrained(input string name);
        vectors++;
        if (expStop.size() != 0 || expLoop.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_pending got stop=%0d loop=%0d outstanding writes, required 0 and 0",
                     name, expStop.size(), expLoop.size());
        end
        expStop.delete();
        expLoop.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        vectors++;
        if ({stopAddr, stopDin, stopEn, stopWe, stopBusy, stopDone, stopWrapped, stopErr, stopReady} !== '0 ||
            {loopAddr, loopDin, loopEn, loopWe, loopBusy, loopDone, loopWrapped, loopErr, loopReady} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got stop addr=%0d din=%h busy=%b rdy=%b loop addr=%0d din=%h busy=%b rdy=%b, required all 0",
                     stopAddr, stopDin, stopBusy, stopReady, loopAddr, loopDin, loopBusy, loopReady);
        end
        reset = 1'b0;
        idle(1);
        vectors++;
        if (stopReady !== 1'b1 || loopReady !== 1'b1 || stopBusy !== 1'b0 || loopBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release got ready=%b/%b busy=%b/%b, required ready=1/1 busy=0/0",
                     stopReady, loopReady, stopBusy, loopBusy);
        end
    endtask

    task automatic test_basic;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        vectors++;
        if (stopBusy !== 1'b1 || loopBusy !== 1'b1 || stopEn !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_busy got busy=%b/%b en=%b, required 1/1 en=1", stopBusy, loopBusy, stopEn);
        end
        sendR(24'h7FFFFF);
        pushBoth(16'd0, packFrame(24'h123456, 24'hABCDEF));
        sendL(24'h123456);
        sendR(24'hABCDEF);
        vectors++;
        if (stopWe !== 1'b1 || stopAddr !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL basic_we_timing got we=%b addr=%0d, required we=1 addr=0", stopWe, stopAddr);
        end
        idle(1);
        vectors++;
        if (stopAddr !== 16'd1 || stopWe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_addr_inc got addr=%0d we=%b, required addr=1 we=0", stopAddr, stopWe);
        end
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        idle(2);
        checkDrained("basic");
    endtask

    task automatic test_sync;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        pushBoth(16'd0, packFrame(24'h111111, 24'h222222));
        sendR(24'h000001);
        sendL(24'h111111);
        sendR(24'h222222);
        idle(1);
        vectors++;
        if (stopErr !== 1'b0 || loopErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sync_no_err got sync_err=%b/%b, required 0/0", stopErr, loopErr);
        end
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        idle(2);
        checkDrained("sync");
    endtask

    task automatic test_boundary;
        logic [23:0] l, r;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        sendR(24'h0F0F0F);
        for (int i = 0; i < 6; i++) begin
            l = 24'h010203 * (i + 1);
            r = 24'h0A0B0C * (i + 1);
            if (i < 4) expStop.push_back('{addr: 16'(i), din: packFrame(l, r)});
            expLoop.push_back('{addr: 16'(i % 4), din: packFrame(l, r)});
            sendL(l);
            sendR(r);
        end
        idle(2);
        vectors++;
        if (stopDone !== 1'b1 || stopBusy !== 1'b0 || stopEn !== 1'b0 || stopWrapped !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL boundary_stop got done=%b busy=%b en=%b wrapped=%b, required 1 0 0 0",
                     stopDone, stopBusy, stopEn, stopWrapped);
        end
        vectors++;
        if (loopWrapped !== 1'b1 || loopDone !== 1'b0 || loopBusy !== 1'b1 || loopAddr !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL boundary_loop got wrapped=%b done=%b busy=%b addr=%0d, required 1 0 1 addr=2",
                     loopWrapped, loopDone, loopBusy, loopAddr);
        end
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        idle(2);
        checkDrained("boundary");
    endtask

    task automatic test_sync_err;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        vectors++;
        if (stopDone !== 1'b0 || stopBusy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL restart_from_done got done=%b busy=%b, required done=0 busy=1", stopDone, stopBusy);
        end
        sendR(24'h333333);
        pushBoth(16'd0, packFrame(24'hBBBBBB, 24'hCCCCCC));
        sendL(24'hAAAAAA);
        sendL(24'hBBBBBB);
        vectors++;
        if (stopErr !== 1'b1 || loopErr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sync_err_set got sync_err=%b/%b, required 1/1", stopErr, loopErr);
        end
        sendR(24'hCCCCCC);
        idle(1);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        idle(2);
        vectors++;
        if (stopErr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sync_err_sticky got sync_err=%b, required 1", stopErr);
        end
        checkDrained("sync_err");
    endtask

    task automatic test_stop;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        sendR(24'h444444);
        sendL(24'h555555);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        vectors++;
        if (stopBusy !== 1'b0 || loopBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_cap_r got busy=%b/%b, required 0/0", stopBusy, loopBusy);
        end
        idle(2);
        checkDrained("stop_cap_r");
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        sendR(24'h666666);
        pushBoth(16'd0, packFrame(24'h102030, 24'h405060));
        pushBoth(16'd1, packFrame(24'h708090, 24'hA0B0C0));
        sendL(24'h102030);
        sendR(24'h405060);
        sendL(24'h708090);
        sendR(24'hA0B0C0);
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        vectors++;
        if (stopBusy !== 1'b0 || stopAddr !== 16'd1 || loopAddr !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL stop_write got busy=%b addr=%0d/%0d, required busy=0 addr=1/1",
                     stopBusy, stopAddr, loopAddr);
        end
        idle(2);
        checkDrained("stop_write");
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        vectors++;
        if (stopBusy !== 1'b0 || loopBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_stop_same got busy=%b/%b, required 0/0", stopBusy, loopBusy);
        end
    endtask

    task automatic test_reset_mid;
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
        sendR(24'h777777);
        sendL(24'h888888);
        reset = 1'b1;
        sendR(24'h999999);
        vectors++;
        if ({stopWe, stopBusy, stopEn, stopAddr, stopDin, stopReady} !== '0 ||
            {loopWe, loopBusy, loopEn, loopAddr, loopDin, loopReady} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid got we=%b busy=%b din=%h rdy=%b, required all 0",
                     stopWe, stopBusy, stopDin, stopReady);
        end
        reset = 1'b0;
        idle(2);
        checkDrained("reset_mid");
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        test_reset();
        test_basic();
        test_sync();
        test_boundary();
        test_sync_err();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_recorder.md
# audio_recorder

Capture side of the audio path: takes the stereo sample stream from the I2S receiver's AXI-Stream output and writes it into the audio BRAM, so the playback side can read it back later. Each stereo frame is packed into one 32-bit word and stored at one address. The address range is the same one the playback reader sweeps: 0..RAM_DEPTH inclusive. The block sits beside the playback address generator on the 22.591 MHz audio clock and drives BRAM port A while recording.

## Interface
- RAM_DEPTH, 65278, last valid BRAM address (inclusive); matches playback wrap point
- ADDR_W, 16, BRAM address width
- LOOP, 0, 1 = wrap to address 0 when full and keep recording; 0 = stop when full
- clock  in  1  audio clock (clk_22m591 domain); all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin recording at address 0
- stop  in  1  one-cycle pulse: abort recording
- s_axis_tdata  in  32  receiver sample, 24-bit signed in [23:0]
- s_axis_tvalid  in  1  sample valid
- s_axis_tlast  in  1  0 = left channel, 1 = right channel
- s_axis_tready  out  1  always 1 after reset; samples are never back-pressured
- bram_addr  out  ADDR_W  write address
- bram_din  out  32  packed frame
- bram_en  out  1  BRAM enable, asserted while recording
- bram_we  out  1  one-cycle write strobe
- busy  out  1  recording in progress
- done  out  1  sticky; buffer filled with LOOP=0
- wrapped  out  1  sticky; at least one wrap occurred with LOOP=1
- sync_err  out  1  sticky; an out-of-order channel was seen during recording

## Operation
- Reset values:
  - all outputs 0, except s_axis_tready, which is 0 during reset and 1 from the first cycle after reset.
  - State is IDLE and the address counter is 0.
- A sample is accepted when s_axis_tvalid is high (tready is always 1).
- States: IDLE, SYNC, CAP_L, CAP_R, WRITE, DONE.
- IDLE: accepted samples are discarded.
  - start -> SYNC; address is cleared; done, wrapped and sync_err are cleared.
  - If start and stop arrive in the same cycle, stop wins and the block stays IDLE.
- SYNC: discard samples until a right sample is accepted, then go to CAP_L. This guarantees the first stored frame is a complete L/R pair.
- CAP_L:
  - A left sample is latched into bram_din[31:16] as s_axis_tdata[23:8], then -> CAP_R.
  - A right sample is discarded, sync_err is set, and the state stays CAP_L.
- CAP_R:
  - A right sample is latched into bram_din[15:0] as s_axis_tdata[23:8], then -> WRITE.
  - A left sample overwrites [31:16], sync_err is set, and the state stays CAP_R.
- WRITE: bram_we=1 for exactly this cycle at the current bram_addr.
  - If bram_addr == RAM_DEPTH:
    - LOOP=0 -> DONE with done=1.
    - LOOP=1 -> address becomes 0, wrapped=1, -> CAP_L.
  - Otherwise address +1 -> CAP_L.
  - A sample arriving in the WRITE cycle is a left sample by protocol and is latched as in CAP_L, so the next state is CAP_R. Samples are never lost.
- DONE: busy=0, bram_en=0, samples discarded. start restarts exactly as from IDLE.
- stop in SYNC, CAP_L or CAP_R: go to IDLE; a half-captured frame is dropped (no write).
- stop in WRITE: the write completes, then the block goes to IDLE. The address keeps its final value for inspection.
- busy = state is SYNC, CAP_L, CAP_R or WRITE. bram_en = busy.
- Address arithmetic is ADDR_W-bit unsigned. The compare is against RAM_DEPTH, never 2^ADDR_W-1.

## Timing
- start at cycle t -> busy=1 at t+1.
- Right sample accepted in CAP_R at cycle t -> bram_we=1 at t+1, with bram_din and bram_addr stable in that same cycle.
- Address increments at t+2.
- Back-to-back samples at the full clock rate are sustained: minimum two cycles per frame, since WRITE overlaps the next left capture.
- done and wrapped assert in the cycle after the final WRITE.
- Reset asserted mid-recording: the next cycle is IDLE with all outputs at reset values. A write in flight is dropped.

## Structure
- Shared package audio_pkg holds:
  - the recorder state enum;
  - ADDR_W, AUDIO_W=24 and PACK_W=16 constants;
  - the channel encoding (TLAST_LEFT=0, TLAST_RIGHT=1), shared with the playback path.
- One natural sub-module: stereo_packer. It does the L/R latching, the [23:8] truncation and the sync_err detection, with the FSM and address counter kept in audio_recorder.

## Test plan
- Reset then start, then sequence L=0x123456, R=0xABCDEF -> one write, addr 0, din 0x1234ABCD.
- start, then the stream begins with R=0x000001, L=0x111111, R=0x222222 -> first R discarded in SYNC. First write holds L=0x111111 and R=0x222222: addr 0, din 0x11112222. sync_err stays 0.
- RAM_DEPTH=3, LOOP=0, 5 frames -> writes at addr 0..3, done=1 after 4th write, 5th frame not written, busy=0.
- RAM_DEPTH=3, LOOP=1, 6 frames -> addrs 0,1,2,3,0,1. wrapped=1 after the 4th write.
- Stream L, L, R during capture -> sync_err=1. The frame is written with the second L.
- stop in CAP_R -> no write. stop in WRITE -> that write happens, then IDLE. start+stop in the same cycle in IDLE -> stays IDLE.
